// File: rtl/alu_sequencer_if.sv
// Request/response bundle between alu_sequencer (master) and the MIU / ALU593 (slave side).
interface alu_sequencer_if #(
    parameter int DW = 8,
    parameter int AW = 14
);
    logic            load;
    logic            store;
    logic [AW-1:0]   mem_addr;
    logic [2*DW-1:0] mem_wdata;
    logic            mem_done;
    logic [DW-1:0]   mem_rdata;
    logic            alu_start;
    logic [DW-1:0]   alu_a;
    logic [DW-1:0]   alu_b;
    logic [3:0]      alu_op;
    logic            alu_done;
    logic [2*DW-1:0] alu_result;

    modport master (
        output load, store, mem_addr, mem_wdata, alu_start, alu_a, alu_b, alu_op,
        input  mem_done, mem_rdata, alu_done, alu_result
    );

    modport slave (
        input  load, store, mem_addr, mem_wdata, alu_start, alu_a, alu_b, alu_op,
        output mem_done, mem_rdata, alu_done, alu_result
    );
endinterface

// File: rtl/alu_sequencer.sv
// TinyALU instruction sequencer: fetches from a program RAM and drives load/store requests
// to the MIU and start/done operations to ALU593, holding operand and result registers.
module alu_sequencer #(
    parameter int DW    = 8,
    parameter int AW    = 14,
    parameter int DEPTH = 1024,
    parameter int NREG  = 2,
    localparam int PCW  = $clog2(DEPTH),
    localparam int RSW  = (NREG > 1) ? $clog2(NREG) : 1,
    localparam int IW   = 4 + AW + 2 * RSW
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           go,
    input  logic           prog_we,
    input  logic [PCW-1:0] prog_addr,
    input  logic [IW-1:0]  prog_wdata,
    alu_sequencer_if.master bus,
    output logic           busy,
    output logic           halted,
    output logic           err,
    output logic [PCW-1:0] pc
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] FETCH    = 3'd1;
    localparam logic [2:0] EXEC     = 3'd2;
    localparam logic [2:0] MEM_WAIT = 3'd3;
    localparam logic [2:0] ALU_WAIT = 3'd4;
    localparam logic [2:0] HALT     = 3'd5;

    localparam logic [3:0] OP_LOAD  = 4'b1000;
    localparam logic [3:0] OP_STORE = 4'b1001;
    localparam logic [3:0] OP_HALT  = 4'b1100;
    localparam logic [3:0] OP_ILL   = 4'b1101;
    localparam logic [3:0] OP_RST   = 4'b1110;

    logic [2:0]                 state;
    logic [IW-1:0]              instr;
    logic [IW-1:0]              imem [DEPTH];
    logic [NREG-1:0][DW-1:0]    regs;
    logic [2*DW-1:0]            result;

    logic [3:0]     i_op;
    logic [AW-1:0]  i_addr;
    logic [RSW-1:0] i_rd;
    logic [RSW-1:0] i_rs;
    logic [DW-1:0]  opa;
    logic [DW-1:0]  opb;
    logic           is_alu;
    logic           last_pc;

    assign i_op    = instr[IW-1 -: 4];
    assign i_addr  = instr[2*RSW +: AW];
    assign i_rd    = instr[RSW +: RSW];
    assign i_rs    = instr[0 +: RSW];
    assign is_alu  = ((i_op >= 4'd1) && (i_op <= 4'd7)) || (i_op == 4'd10) || (i_op == 4'd11);
    assign last_pc = (pc == PCW'(DEPTH - 1));
    assign busy    = (state != IDLE) && (state != HALT);

    // Selectors beyond NREG match no register and therefore read as zero.
    always_comb begin
        opa = '0;
        opb = '0;
        for (int i = 0; i < NREG; i++) begin
            if (i_rd == RSW'(i)) opa = regs[i];
            if (i_rs == RSW'(i)) opb = regs[i];
        end
    end

    // Program RAM is only writable while the sequencer is parked; contents survive reset.
    always_ff @(posedge clk) begin
        if (prog_we && !busy) imem[prog_addr] <= prog_wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            pc            <= '0;
            instr         <= '0;
            regs          <= '0;
            result        <= '0;
            halted        <= 1'b0;
            err           <= 1'b0;
            bus.load      <= 1'b0;
            bus.store     <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.alu_start <= 1'b0;
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.alu_op    <= '0;
        end else begin
            bus.alu_start <= 1'b0;
            case (state)
                IDLE, HALT: begin
                    if (go) begin
                        pc     <= '0;
                        err    <= 1'b0;
                        halted <= 1'b0;
                        state  <= FETCH;
                    end
                end
                FETCH: begin
                    instr <= imem[pc];
                    state <= EXEC;
                end
                EXEC: begin
                    if (is_alu) begin
                        bus.alu_start <= 1'b1;
                        bus.alu_op    <= i_op;
                        bus.alu_a     <= opa;
                        bus.alu_b     <= opb;
                        state         <= ALU_WAIT;
                    end else if (i_op == OP_LOAD) begin
                        bus.load     <= 1'b1;
                        bus.mem_addr <= i_addr;
                        state        <= MEM_WAIT;
                    end else if (i_op == OP_STORE) begin
                        bus.store     <= 1'b1;
                        bus.mem_addr  <= i_addr;
                        bus.mem_wdata <= result;
                        state         <= MEM_WAIT;
                    end else if ((i_op == OP_HALT) || (i_op == OP_ILL)) begin
                        halted <= 1'b1;
                        err    <= (i_op == OP_ILL);
                        state  <= HALT;
                    end else begin
                        if (i_op == OP_RST) begin
                            regs   <= '0;
                            result <= '0;
                        end
                        halted <= last_pc;
                        state  <= last_pc ? HALT : FETCH;
                        if (!last_pc) pc <= pc + 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (bus.mem_done) begin
                        if (bus.load) begin
                            for (int i = 0; i < NREG; i++) begin
                                if (i_rd == RSW'(i)) regs[i] <= bus.mem_rdata;
                            end
                        end
                        bus.load  <= 1'b0;
                        bus.store <= 1'b0;
                        halted    <= last_pc;
                        state     <= last_pc ? HALT : FETCH;
                        if (!last_pc) pc <= pc + 1'b1;
                    end
                end
                ALU_WAIT: begin
                    if (bus.alu_done) begin
                        result <= bus.alu_result;
                        halted <= last_pc;
                        state  <= last_pc ? HALT : FETCH;
                        if (!last_pc) pc <= pc + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: table of single-instruction programs plus multi-cycle sequences.
module tb_alu_sequencer;
    localparam int DW = 8, AW = 14, DEPTH = 1024, NREG = 2;
    localparam int PCW = 10, IW = 20;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           go = 1'b0;
    logic           prog_we = 1'b0;
    logic [PCW-1:0] prog_addr = '0;
    logic [IW-1:0]  prog_wdata = '0;
    logic           busy, halted, err;
    logic [PCW-1:0] pc;

    alu_sequencer_if #(.DW(DW), .AW(AW)) bus ();

    alu_sequencer #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .NREG(NREG)) dut (
        .clk(clk), .reset_n(reset_n), .go(go), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .bus(bus), .busy(busy), .halted(halted), .err(err), .pc(pc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    int          mem_lat = 1, alu_lat = 1;
    logic [15:0] alu_resp = '0;
    int          first_kind;
    logic [13:0] seen_addr;
    logic [15:0] seen_wdata;
    logic [7:0]  seen_a, seen_b;
    logic [3:0]  seen_op;

    typedef struct {
        logic [3:0]  op;
        logic [13:0] addr;
        logic        rd, rs;
        logic [15:0] resp;
        int          kind;     // 0 none, 1 load, 2 store, 3 alu
        logic [13:0] e_addr;
        logic [15:0] e_wdata;
        logic [7:0]  e_a, e_b;
    } vec_t;
    vec_t tbl [15];

    function automatic logic [IW-1:0] mk(input logic [3:0] op, input logic [13:0] a,
                                         input logic rd, input logic rs);
        return {op, a, rd, rs};
    endfunction

    function automatic logic [7:0] mem_model(input logic [13:0] a);
        case (a)
            14'h10:  return 8'h25;
            14'h11:  return 8'h13;
            default: return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_instr(input logic [PCW-1:0] a, input logic [IW-1:0] w);
        prog_we = 1'b1; prog_addr = a; prog_wdata = w;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic start();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic wait_req();
        for (int i = 0; i < 50 && !(bus.load || bus.store || bus.alu_start); i++) tick();
    endtask

    // Acts as MIU and ALU until the sequencer halts, recording what it was asked to do.
    task automatic serve(input string name, input int budget);
        int cyc = 0;
        first_kind = 0;
        while (!halted && cyc < budget) begin
            if (bus.alu_start) begin
                if (first_kind == 0) first_kind = 3;
                seen_a = bus.alu_a; seen_b = bus.alu_b; seen_op = bus.alu_op;
                repeat (alu_lat) tick();
                bus.alu_done = 1'b1; bus.alu_result = alu_resp;
                tick();
                bus.alu_done = 1'b0;
                cyc += alu_lat + 1;
            end else if (bus.load || bus.store) begin
                if (first_kind == 0) first_kind = bus.load ? 1 : 2;
                seen_addr = bus.mem_addr;
                if (bus.store) seen_wdata = bus.mem_wdata;
                repeat (mem_lat) tick();
                bus.mem_done = 1'b1; bus.mem_rdata = mem_model(bus.mem_addr);
                tick();
                bus.mem_done = 1'b0;
                cyc += mem_lat + 1;
            end else begin
                tick();
                cyc++;
            end
        end
        check({name, " halted"}, halted, 1);
    endtask

    initial begin
        int cyc;
        bus.mem_done = 1'b0; bus.mem_rdata = '0; bus.alu_done = 1'b0; bus.alu_result = '0;

        tbl[0]  = '{4'h9, 14'h0005, 1'b0, 1'b0, 16'h0000, 2, 14'h0005, 16'h0000, 8'h00, 8'h00};
        tbl[1]  = '{4'h8, 14'h0010, 1'b0, 1'b0, 16'h0000, 1, 14'h0010, 16'h0000, 8'h00, 8'h00};
        tbl[2]  = '{4'h8, 14'h0011, 1'b1, 1'b0, 16'h0000, 1, 14'h0011, 16'h0000, 8'h00, 8'h00};
        tbl[3]  = '{4'h1, 14'h0000, 1'b0, 1'b1, 16'h0038, 3, 14'h0000, 16'h0000, 8'h25, 8'h13};
        tbl[4]  = '{4'h9, 14'h0012, 1'b0, 1'b0, 16'h0000, 2, 14'h0012, 16'h0038, 8'h00, 8'h00};
        tbl[5]  = '{4'h2, 14'h0000, 1'b1, 1'b0, 16'hABCD, 3, 14'h0000, 16'h0000, 8'h13, 8'h25};
        tbl[6]  = '{4'h9, 14'h3FFF, 1'b0, 1'b0, 16'h0000, 2, 14'h3FFF, 16'hABCD, 8'h00, 8'h00};
        tbl[7]  = '{4'hE, 14'h0000, 1'b0, 1'b0, 16'h0000, 0, 14'h0000, 16'h0000, 8'h00, 8'h00};
        tbl[8]  = '{4'h9, 14'h0001, 1'b0, 1'b0, 16'h0000, 2, 14'h0001, 16'h0000, 8'h00, 8'h00};
        tbl[9]  = '{4'hB, 14'h0000, 1'b0, 1'b1, 16'h00FF, 3, 14'h0000, 16'h0000, 8'h00, 8'h00};
        tbl[10] = '{4'h8, 14'h003C, 1'b1, 1'b0, 16'h0000, 1, 14'h003C, 16'h0000, 8'h00, 8'h00};
        tbl[11] = '{4'hA, 14'h0000, 1'b1, 1'b1, 16'h1111, 3, 14'h0000, 16'h0000, 8'h66, 8'h66};
        tbl[12] = '{4'hF, 14'h0000, 1'b0, 1'b0, 16'h0000, 0, 14'h0000, 16'h0000, 8'h00, 8'h00};
        tbl[13] = '{4'h9, 14'h0000, 1'b0, 1'b0, 16'h0000, 2, 14'h0000, 16'h1111, 8'h00, 8'h00};
        tbl[14] = '{4'h7, 14'h0000, 1'b1, 1'b0, 16'h0000, 3, 14'h0000, 16'h0000, 8'h66, 8'h00};

        repeat (3) tick();
        check("reset ctl", {bus.load, bus.store, bus.alu_start, busy, halted, err}, 0);
        check("reset data", {bus.mem_addr, bus.mem_wdata, bus.alu_a, bus.alu_b, bus.alu_op, pc}, 0);
        reset_n = 1'b1;
        tick();

        // Single-instruction programs followed by halt; registers carry over between vectors.
        for (int i = 0; i < 15; i++) begin
            write_instr(0, mk(tbl[i].op, tbl[i].addr, tbl[i].rd, tbl[i].rs));
            write_instr(1, mk(4'hC, 14'h0, 1'b0, 1'b0));
            alu_resp = tbl[i].resp;
            start();
            serve($sformatf("v%0d", i), 200);
            check($sformatf("v%0d kind", i), first_kind, tbl[i].kind);
            if (tbl[i].kind == 1 || tbl[i].kind == 2)
                check($sformatf("v%0d mem_addr", i), seen_addr, tbl[i].e_addr);
            if (tbl[i].kind == 2)
                check($sformatf("v%0d mem_wdata", i), seen_wdata, tbl[i].e_wdata);
            if (tbl[i].kind == 3) begin
                check($sformatf("v%0d alu_a", i), seen_a, tbl[i].e_a);
                check($sformatf("v%0d alu_b", i), seen_b, tbl[i].e_b);
                check($sformatf("v%0d alu_op", i), seen_op, tbl[i].op);
            end
            check($sformatf("v%0d pc", i), pc, 1);
        end

        // Full program with slow MIU.
        write_instr(0, mk(4'h8, 14'h10, 1'b0, 1'b0));
        write_instr(1, mk(4'h8, 14'h11, 1'b1, 1'b0));
        write_instr(2, mk(4'h1, 14'h0, 1'b0, 1'b1));
        write_instr(3, mk(4'h9, 14'h12, 1'b0, 1'b0));
        write_instr(4, mk(4'hC, 14'h0, 1'b0, 1'b0));
        mem_lat = 3; alu_lat = 2; alu_resp = 16'h0038;
        start();
        serve("prog", 300);
        check("prog alu_a", seen_a, 8'h25);
        check("prog alu_b", seen_b, 8'h13);
        check("prog store addr", seen_addr, 14'h12);
        check("prog store data", seen_wdata, 16'h0038);
        check("prog pc", pc, 4);
        check("prog err", err, 0);

        // go / prog_we while busy must be ignored.
        mem_lat = 1;
        write_instr(0, mk(4'h8, 14'h20, 1'b0, 1'b0));
        write_instr(1, mk(4'hC, 14'h0, 1'b0, 1'b0));
        start();
        wait_req();
        check("busy load", bus.load, 1);
        go = 1'b1; prog_we = 1'b1; prog_addr = 0; prog_wdata = mk(4'hC, 14'h0, 1'b0, 1'b0);
        tick();
        go = 1'b0; prog_we = 1'b0;
        check("busy pc", pc, 0);
        check("busy still load", bus.load, 1);
        serve("busy run", 100);
        check("busy run pc", pc, 1);
        start();
        serve("busy rerun", 100);
        check("busy rerun kind", first_kind, 1);
        check("busy rerun addr", seen_addr, 14'h20);

        // Spurious completions in the wrong wait state.
        write_instr(0, mk(4'h8, 14'h30, 1'b0, 1'b0));
        write_instr(1, mk(4'h3, 14'h0, 1'b0, 1'b0));
        write_instr(2, mk(4'h9, 14'h31, 1'b0, 1'b0));
        write_instr(3, mk(4'h2, 14'h0, 1'b0, 1'b0));
        write_instr(4, mk(4'hC, 14'h0, 1'b0, 1'b0));
        start();
        wait_req();
        check("spur load", bus.load, 1);
        bus.alu_done = 1'b1; bus.alu_result = 16'hFFFF;
        tick();
        bus.alu_done = 1'b0;
        check("spur mem hold", {bus.load, bus.mem_addr, busy, pc}, {1'b1, 14'h30, 1'b1, 10'd0});
        bus.mem_done = 1'b1; bus.mem_rdata = 8'h07;
        tick();
        bus.mem_done = 1'b0;
        check("spur load done", bus.load, 0);
        wait_req();
        check("spur alu start", {bus.alu_start, bus.alu_a, bus.alu_op}, {1'b1, 8'h07, 4'h3});
        bus.mem_done = 1'b1; bus.mem_rdata = 8'hEE;
        tick();
        bus.mem_done = 1'b0;
        check("spur alu hold", {bus.alu_a, bus.alu_b, bus.alu_op, busy, pc},
              {8'h07, 8'h07, 4'h3, 1'b1, 10'd1});
        bus.alu_done = 1'b1; bus.alu_result = 16'h1234;
        tick();
        bus.alu_done = 1'b0;
        alu_resp = 16'h0;
        serve("spur run", 100);
        check("spur store data", seen_wdata, 16'h1234);
        check("spur R0 kept", seen_a, 8'h07);
        check("spur pc", pc, 4);

        // Run off the end of a RAM full of nops.
        for (int i = 0; i < DEPTH; i++)
            write_instr(PCW'(i), mk(i[0] ? 4'hF : 4'h0, 14'(i), 1'b0, 1'b0));
        start();
        cyc = 1;
        while (!halted && cyc < 5000) begin
            tick();
            cyc++;
        end
        check("nop cycles", cyc, 2 * DEPTH + 1);
        check("nop halted", halted, 1);
        check("nop pc", pc, DEPTH - 1);
        check("nop err", err, 0);

        // Illegal opcode at pc=3, then restart.
        write_instr(3, mk(4'hD, 14'h0, 1'b0, 1'b0));
        start();
        serve("ill", 100);
        check("ill err", err, 1);
        check("ill pc", pc, 3);
        start();
        check("ill restart", {err, halted, busy, pc}, {1'b0, 1'b0, 1'b1, 10'd0});
        serve("ill again", 100);
        check("ill again err", err, 1);

        // Asynchronous reset in the middle of a load.
        write_instr(0, mk(4'h8, 14'h10, 1'b0, 1'b0));
        start();
        wait_req();
        check("rst pre load", bus.load, 1);
        #2 reset_n = 1'b0;
        #1;
        check("rst mid ctl", {bus.load, bus.store, bus.alu_start, busy, halted, err}, 0);
        check("rst mid data", {bus.mem_addr, bus.mem_wdata, bus.alu_a, bus.alu_b, bus.alu_op, pc}, 0);
        tick();
        reset_n = 1'b1;
        tick();
        check("rst idle", {busy, bus.load}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
